// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with anti-ghost blanking,
// frame-synchronous input shadowing and leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 6000,
    parameter int BLANK_CYC = 60
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DIG0,
    input  logic [3:0] DIG1,
    input  logic [3:0] DIG2,
    input  logic [3:0] DIG3,
    input  logic [3:0] DP_EN,
    input  logic       LZB,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN,
    output logic       FRAME
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_VAL = PW'(BLANK_CYC);

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      dp_en_q, dp_en_d;
    logic            lzb_q, lzb_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            dp_q, dp_d;
    logic            frame_q, frame_d;

    logic            slot_end;
    logic            frame_end;
    logic            blank_win;
    logic            lz_blank;
    logic [3:0]      upper_zero;

    // upper_zero[k] is set when shadow digits k..3 are all zero
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_upper_zero
            assign upper_zero[gi] = ~|dig_q[3:gi];
        end
    endgenerate

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (pcnt_q == PCNT_MAX);
        frame_end = slot_end && (idx_q == 2'd3);
        blank_win = (pcnt_q < BLANK_VAL);
        lz_blank  = lzb_q && (idx_q != 2'd0) && upper_zero[idx_q];

        pcnt_d  = slot_end ? '0 : pcnt_q + PW'(1);
        idx_d   = slot_end ? idx_q + 2'd1 : idx_q;

        dig_d   = dig_q;
        dp_en_d = dp_en_q;
        lzb_d   = lzb_q;
        if (frame_end) begin
            dig_d   = {DIG3, DIG2, DIG1, DIG0};
            dp_en_d = DP_EN;
            lzb_d   = LZB;
        end

        seg_d   = 7'h7F;
        an_d    = 4'hF;
        dp_d    = 1'b1;
        frame_d = frame_end;
        if (!blank_win) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank ? 7'h7F : seg_decode(dig_q[idx_q]);
            dp_d  = ~dp_en_q[idx_q];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pcnt_q  <= '0;
            idx_q   <= '0;
            dig_q   <= '0;
            dp_en_q <= '0;
            lzb_q   <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            dp_en_q <= dp_en_d;
            lzb_q   <= lzb_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign DP    = dp_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-count based reference model compared every
// cycle, plus directed checks with hand-computed display values.
module tb_seg7_scan_ctrl;

    localparam int SD = 10;
    localparam int BC = 2;
    localparam int FP = 4 * SD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dig0 = '0, dig1 = '0, dig2 = '0, dig3 = '0;
    logic [3:0] dp_en = '0;
    logic       lzb = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .CLK(clk), .RESET(rst_n),
        .DIG0(dig0), .DIG1(dig1), .DIG2(dig2), .DIG3(dig3),
        .DP_EN(dp_en), .LZB(lzb),
        .SEG(seg), .DP(dp), .AN(an), .FRAME(frame)
    );

    // ---------------- reference model ----------------
    function automatic logic [6:0] ref_font(input int v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        return t[v];
    endfunction

    int unsigned cyc_m = 0;      // clock edges since reset release
    int          m_dig [4] = '{0, 0, 0, 0};
    logic [3:0]  m_dpen = '0;
    logic        m_lzb  = 1'b0;
    logic [6:0]  e_seg  = 7'h7F;
    logic [3:0]  e_an   = 4'hF;
    logic        e_dp   = 1'b1;
    logic        e_frame = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc_m = 0;
                m_dig = '{0, 0, 0, 0};
                m_dpen = '0;
                m_lzb = 1'b0;
                e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_frame = 1'b0;
            end else begin
                int pos, slot;
                bit nonzero_above;
                pos  = cyc_m % SD;
                slot = (cyc_m / SD) % 4;
                if (pos < BC) begin
                    e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
                end else begin
                    nonzero_above = 0;
                    for (int k = slot; k < 4; k++) if (m_dig[k] != 0) nonzero_above = 1;
                    e_an = 4'hF;
                    e_an[slot] = 1'b0;
                    e_seg = (m_lzb && slot > 0 && !nonzero_above) ? 7'h7F : ref_font(m_dig[slot]);
                    e_dp = !m_dpen[slot];
                end
                e_frame = ((cyc_m % FP) == FP - 1);
                if ((cyc_m % FP) == FP - 1) begin
                    m_dig  = '{int'(dig0), int'(dig1), int'(dig2), int'(dig3)};
                    m_dpen = dp_en;
                    m_lzb  = lzb;
                end
                cyc_m++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                tests++;
                if ({seg, an, dp, frame} !== {e_seg, e_an, e_dp, e_frame}) begin
                    fails++;
                    if (fails < 40)
                        $display("FAIL model t=%0t: got seg=%h an=%b dp=%b frame=%b, expected seg=%h an=%b dp=%b frame=%b",
                                 $time, seg, an, dp, frame, e_seg, e_an, e_dp, e_frame);
                end
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic check_eq(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame !== 1'b1 && n < 2 * FP);
        tests++;
        if (frame !== 1'b1) begin
            fails++;
            $display("FAIL frame_timeout: got no FRAME in %0d cycles, expected one", n);
        end
    endtask

    // After FRAME, slot s is visible at negedges 10s+3 .. 10s+10; sample at 10s+5.
    task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpx);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        exp_seg = '{s0, s1, s2, s3};
        wait_frame();
        for (int s = 0; s < 4; s++) begin
            repeat ((s == 0) ? 5 : 10) @(negedge clk);
            exp_an = 4'hF;
            exp_an[s] = 1'b0;
            check_eq($sformatf("%s_an%0d", name, s), {4'h0, an}, {4'h0, exp_an});
            check_eq($sformatf("%s_seg%0d", name, s), {1'b0, seg}, {1'b0, exp_seg[s]});
            check_eq($sformatf("%s_dp%0d", name, s), {7'h0, dp}, {7'h0, dpx[s]});
        end
        $display("[TB] frame check %s done", name);
    endtask

    initial begin
        int n, nblank, nframe;
        int ndig [4];

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_an", {4'h0, an}, 8'h0F);
        check_eq("rst_seg", {1'b0, seg}, 8'h7F);
        check_eq("rst_dp", {7'h0, dp}, 8'h01);
        check_eq("rst_frame", {7'h0, frame}, 8'h00);
        #2 rst_n = 1'b1;

        // shadow zeros displayed on digit 0 during frame 0
        repeat (5) @(negedge clk);
        check_eq("f0_an", {4'h0, an}, 8'h0E);
        check_eq("f0_seg", {1'b0, seg}, 8'h40);
        check_eq("f0_dp", {7'h0, dp}, 8'h01);

        // 1,2,3,4 with DP on digit 1
        dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd3; dig0 = 4'd4; dp_en = 4'b0010; lzb = 1'b0;
        check_frame("d1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1101);

        // DIG0 change mid-frame only shows after the next FRAME
        wait_frame();
        repeat (5) @(negedge clk);
        check_eq("hold_seg0", {1'b0, seg}, 8'h19);
        repeat (10) @(negedge clk);
        dig0 = 4'd7;
        check_frame("d1237", 7'h78, 7'h30, 7'h24, 7'h79, 4'b1101);

        // leading-zero blanking
        dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd0; dig0 = 4'd0; dp_en = 4'b0000; lzb = 1'b1;
        check_frame("lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        dig2 = 4'd5; dp_en = 4'b1001;
        check_frame("lz0500", 7'h40, 7'h40, 7'h12, 7'h7F, 4'b0110);

        // codes above 9 decode as dash
        lzb = 1'b0; dig2 = 4'd0; dig0 = 4'd12; dp_en = 4'b0000;
        check_frame("dash12", 7'h3F, 7'h40, 7'h40, 7'h40, 4'b1111);
        dig0 = 4'd15;
        check_frame("dash15", 7'h3F, 7'h40, 7'h40, 7'h40, 4'b1111);

        // timing over one full frame
        wait_frame();
        nblank = 0; nframe = 0; ndig = '{0, 0, 0, 0};
        for (int c = 0; c < FP; c++) begin
            @(negedge clk);
            if (an == 4'hF) nblank++;
            for (int k = 0; k < 4; k++) if (an == ~(4'b0001 << k)) ndig[k]++;
            if (frame) nframe++;
        end
        check_eq("blank_cycles", 8'(nblank), 8'd8);
        for (int k = 0; k < 4; k++) check_eq($sformatf("digit%0d_cycles", k), 8'(ndig[k]), 8'd8);
        check_eq("frame_pulses", 8'(nframe), 8'd1);

        // asynchronous reset mid-slot
        wait_frame();
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_an", {4'h0, an}, 8'h0F);
        check_eq("arst_seg", {1'b0, seg}, 8'h7F);
        check_eq("arst_dp", {7'h0, dp}, 8'h01);
        check_eq("arst_frame", {7'h0, frame}, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame !== 1'b1 && n < 2 * FP);
        check_eq("first_frame_delay", 8'(n), 8'd40);

        repeat (SD * 2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
